// File: rtl/uart_rx_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_timer
// Brief    : Oversampling timing engine for the UART receiver. Counts
//            prescale edges per bit and bits per frame, with a runtime
//            configurable frame length (data bits, parity, 1 or 2 stop bits).
//            Emits early/mid/late sample strobes for majority voting, plus
//            bit-end and frame-done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_timer #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int MAX_DATA_BITS  = 8,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      start,
    input  logic                      abort,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [3:0]                data_bits,
    input  logic                      par_en,
    input  logic                      stop2,
    output logic                      busy,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic                      smp_early,
    output logic                      smp_mid,
    output logic                      smp_late,
    output logic                      bit_end,
    output logic                      frame_done,
    output logic                      cfg_err
);

    // Width used for frame-length arithmetic: wide enough for both the
    // 4-bit data_bits field and the bit counter.
    localparam int c_cw = (BIT_CNT_WIDTH > 4) ? BIT_CNT_WIDTH : 4;

    localparam logic [PRESCALE_WIDTH-1:0] c_min_prescale = PRESCALE_WIDTH'(4);
    localparam logic [PRESCALE_WIDTH-1:0] c_ps_one       = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] c_ps_zero      = PRESCALE_WIDTH'(0);
    localparam logic [BIT_CNT_WIDTH-1:0]  c_bc_one       = BIT_CNT_WIDTH'(1);
    localparam logic [BIT_CNT_WIDTH-1:0]  c_bc_zero      = BIT_CNT_WIDTH'(0);
    localparam logic [3:0]                c_min_data     = 4'd5;
    localparam logic [3:0]                c_max_data     = 4'(MAX_DATA_BITS);
    localparam logic [c_cw-1:0]           c_cw_one       = c_cw'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [PRESCALE_WIDTH-1:0]  r_edge_cnt;
    logic [PRESCALE_WIDTH-1:0]  w_edge_nxt;
    logic [BIT_CNT_WIDTH-1:0]   r_bit_cnt;
    logic [BIT_CNT_WIDTH-1:0]   w_bit_nxt;
    logic                       r_cfg_err;
    logic                       w_cfg_err_nxt;
    logic                       w_latch_cfg;

    // Configuration captured on the accepted start; held for the whole frame.
    logic [PRESCALE_WIDTH-1:0]  r_prescale_q;
    logic [3:0]                 r_data_bits_q;
    logic                       r_par_en_q;
    logic                       r_stop2_q;

    logic                       w_cfg_legal;
    logic [PRESCALE_WIDTH-1:0]  w_mid;
    logic [PRESCALE_WIDTH-1:0]  w_mid_m1;
    logic [PRESCALE_WIDTH-1:0]  w_mid_p1;
    logic [c_cw-1:0]            w_last_bit;
    logic                       w_on_last_bit;
    logic                       w_edge_last;
    logic                       w_run;
    logic                       w_tick;

    // Legality is judged on the live inputs, since that is what gets latched.
    assign w_cfg_legal = (prescale >= c_min_prescale) &&
                         (data_bits >= c_min_data) &&
                         (data_bits <= c_max_data);

    // Sample points are centred on the half-bit edge of the latched prescale.
    assign w_mid    = r_prescale_q >> 1;
    assign w_mid_m1 = w_mid - c_ps_one;
    assign w_mid_p1 = w_mid + c_ps_one;

    // Index of the final stop bit: FRAME_LEN-1 = data + parity + 1 + stop2.
    assign w_last_bit = c_cw'(r_data_bits_q) + c_cw'(r_par_en_q) +
                        c_cw_one + c_cw'(r_stop2_q);

    assign w_on_last_bit = (c_cw'(r_bit_cnt) == w_last_bit);
    assign w_edge_last   = (r_edge_cnt == r_prescale_q);
    assign w_run         = (r_state == ST_RUN);
    assign w_tick        = w_run && enable;

    // Strobes and pulses are zero-latency decodes of the registered counters,
    // qualified by the oversampling tick so they never fire on idle cycles.
    assign smp_early  = w_tick && (r_edge_cnt == w_mid_m1);
    assign smp_mid    = w_tick && (r_edge_cnt == w_mid);
    assign smp_late   = w_tick && (r_edge_cnt == w_mid_p1);
    assign bit_end    = w_tick && w_edge_last;
    // An abort in the same cycle cancels the frame, so no completion is reported.
    assign frame_done = bit_end && w_on_last_bit && !abort;

    assign busy     = w_run;
    assign edge_cnt = r_edge_cnt;
    assign bit_cnt  = r_bit_cnt;
    assign cfg_err  = r_cfg_err;

    // Next-state and counter update logic for the frame timer.
    always_comb begin
        w_state_nxt   = r_state;
        w_edge_nxt    = r_edge_cnt;
        w_bit_nxt     = r_bit_cnt;
        w_cfg_err_nxt = 1'b0;
        w_latch_cfg   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // abort in IDLE masks start for that cycle
                if (start && enable && !abort) begin
                    if (w_cfg_legal) begin
                        w_state_nxt = ST_RUN;
                        w_edge_nxt  = c_ps_one;
                        w_bit_nxt   = c_bc_zero;
                        w_latch_cfg = 1'b1;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_edge_nxt  = c_ps_zero;
                    w_bit_nxt   = c_bc_zero;
                end else if (enable) begin
                    if (r_edge_cnt < r_prescale_q) begin
                        w_edge_nxt = r_edge_cnt + c_ps_one;
                    end else if (w_on_last_bit) begin
                        w_state_nxt = ST_IDLE;
                        w_edge_nxt  = c_ps_zero;
                        w_bit_nxt   = c_bc_zero;
                    end else begin
                        w_edge_nxt = c_ps_one;
                        w_bit_nxt  = r_bit_cnt + c_bc_one;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_edge_nxt  = c_ps_zero;
                w_bit_nxt   = c_bc_zero;
            end
        endcase
    end

    // State register, counters and the registered configuration-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_edge_cnt <= c_ps_zero;
            r_bit_cnt  <= c_bc_zero;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_edge_cnt <= w_edge_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_cfg_err  <= w_cfg_err_nxt;
        end
    end

    // Frame configuration is captured only when a frame is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale_q  <= c_ps_zero;
            r_data_bits_q <= 4'd0;
            r_par_en_q    <= 1'b0;
            r_stop2_q     <= 1'b0;
        end else if (w_latch_cfg) begin
            r_prescale_q  <= prescale;
            r_data_bits_q <= data_bits;
            r_par_en_q    <= par_en;
            r_stop2_q     <= stop2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame_timer
// Brief    : Self-checking bench for uart_rx_frame_timer. Directed stimulus
//            pushes expected strobe/pulse events and state snapshots, tagged
//            with the cycle they are due, into queues; a negedge monitor
//            pops and compares them against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_timer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       start;
    logic       abort;
    logic [5:0] prescale;
    logic [3:0] data_bits;
    logic       par_en;
    logic       stop2;
    logic       busy;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       smp_early;
    logic       smp_mid;
    logic       smp_late;
    logic       bit_end;
    logic       frame_done;
    logic       cfg_err;

    uart_rx_frame_timer #(
        .PRESCALE_WIDTH (6),
        .MAX_DATA_BITS  (8),
        .BIT_CNT_WIDTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .start      (start),
        .abort      (abort),
        .prescale   (prescale),
        .data_bits  (data_bits),
        .par_en     (par_en),
        .stop2      (stop2),
        .busy       (busy),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .smp_early  (smp_early),
        .smp_mid    (smp_mid),
        .smp_late   (smp_late),
        .bit_end    (bit_end),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    // flags: {cfg_err, frame_done, bit_end, smp_late, smp_mid, smp_early}
    typedef struct {
        int         cyc;
        logic [5:0] flags;
        logic [3:0] bc;
        logic [5:0] ec;
    } ev_t;

    typedef struct {
        int         cyc;
        logic       busy;
        logic [3:0] bc;
        logic [5:0] ec;
    } st_t;

    ev_t evq[$];
    st_t stq[$];
    int  cyc        = 0;
    int  n_cmp      = 0;
    int  n_fail     = 0;
    bit  finish_req = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog: the run must never hang.
    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    // Monitor / scoreboard: compare DUT outputs against queued expectations.
    always @(negedge clk) begin
        logic [5:0] got;
        ev_t        e;
        st_t        s;
        got = {cfg_err, frame_done, bit_end, smp_late, smp_mid, smp_early};

        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            e = evq.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missing_event: at cycle %0d got nothing, required flags=%b bc=%0d ec=%0d",
                     e.cyc, e.flags, e.bc, e.ec);
        end

        if (got != 6'b0) begin
            n_cmp++;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e = evq.pop_front();
                if (got !== e.flags || bit_cnt !== e.bc || edge_cnt !== e.ec) begin
                    n_fail++;
                    $display("FAIL event@%0d: got flags=%b bc=%0d ec=%0d, required flags=%b bc=%0d ec=%0d",
                             cyc, got, bit_cnt, edge_cnt, e.flags, e.bc, e.ec);
                end
            end else begin
                n_fail++;
                $display("FAIL unexpected_event@%0d: got flags=%b bc=%0d ec=%0d, required no event",
                         cyc, got, bit_cnt, edge_cnt);
            end
        end

        while (stq.size() > 0 && stq[0].cyc < cyc) begin
            s = stq.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missed_state_check: cycle %0d passed, required check", s.cyc);
        end
        if (stq.size() > 0 && stq[0].cyc == cyc) begin
            s = stq.pop_front();
            n_cmp++;
            if (busy !== s.busy || bit_cnt !== s.bc || edge_cnt !== s.ec) begin
                n_fail++;
                $display("FAIL state@%0d: got busy=%0d bc=%0d ec=%0d, required busy=%0d bc=%0d ec=%0d",
                         cyc, busy, bit_cnt, edge_cnt, s.busy, s.bc, s.ec);
            end
        end

        if (finish_req) begin
            n_cmp++;
            if (evq.size() != 0 || stq.size() != 0) begin
                n_fail++;
                $display("FAIL queues_drained: got %0d events / %0d states pending, required 0",
                         evq.size(), stq.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_state(input int c, input logic b, input int bc, input int ec);
        st_t s;
        s.cyc  = c;
        s.busy = b;
        s.bc   = 4'(bc);
        s.ec   = 6'(ec);
        stq.push_back(s);
    endtask

    task automatic push_cfg_err(input int c);
        ev_t r;
        r.cyc   = c;
        r.flags = 6'b100000;
        r.bc    = 4'd0;
        r.ec    = 6'd0;
        evq.push_back(r);
    endtask

    // Expected events for one frame: the k-th counted tick shows edge k%ps+1
    // of bit k/ps, visible at cycle first + step*k.
    task automatic push_frame(input int first, input int step, input int ps,
                              input int nbits, input int kmax);
        ev_t r;
        int  e;
        int  b;
        for (int k = 0; k < kmax; k++) begin
            e        = (k % ps) + 1;
            b        = k / ps;
            r.cyc    = first + step * k;
            r.flags  = 6'b0;
            r.flags[0] = (e == ps / 2 - 1);
            r.flags[1] = (e == ps / 2);
            r.flags[2] = (e == ps / 2 + 1);
            r.flags[3] = (e == ps);
            r.flags[4] = (e == ps) && (b == nbits - 1);
            r.bc     = 4'(b);
            r.ec     = 6'(e);
            if (r.flags != 6'b0) evq.push_back(r);
        end
    endtask

    task automatic set_cfg(input int ps, input int db, input logic pe, input logic s2);
        prescale  = 6'(ps);
        data_bits = 4'(db);
        par_en    = pe;
        stop2     = s2;
    endtask

    initial begin
        int p;
        int q;
        rst    = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        set_cfg(8, 8, 1'b0, 1'b0);
        repeat (3) tick();
        push_state(cyc, 1'b0, 0, 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // 8N1, prescale 8: 10 bits, frame_done at start+80; start in RUN ignored
        p = cyc;
        start = 1'b1;
        push_frame(p + 1, 1, 8, 10, 80);
        push_state(p + 1, 1'b1, 0, 1);
        push_state(p + 80, 1'b1, 9, 8);
        push_state(p + 81, 1'b0, 0, 0);
        tick();
        start = 1'b0;
        wait_until(p + 30);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(p + 84);

        // 8E2, prescale 16: 12 bits, frame_done at start+192
        set_cfg(16, 8, 1'b1, 1'b1);
        p = cyc;
        start = 1'b1;
        push_frame(p + 1, 1, 16, 12, 192);
        push_state(p + 192, 1'b1, 11, 16);
        push_state(p + 193, 1'b0, 0, 0);
        tick();
        start = 1'b0;
        wait_until(p + 195);

        // 5N1, prescale 4, enable high one cycle in three: 28 counted ticks
        set_cfg(4, 5, 1'b0, 1'b0);
        while (cyc % 3 != 0) tick();
        p = cyc;
        start  = 1'b1;
        enable = 1'b1;
        push_frame(p + 3, 3, 4, 7, 28);
        push_state(p + 1, 1'b1, 0, 1);
        push_state(p + 84, 1'b1, 6, 4);
        push_state(p + 85, 1'b0, 0, 0);
        tick();
        start  = 1'b0;
        enable = (cyc % 3 == 0);
        while (cyc < p + 87) begin
            tick();
            enable = (cyc % 3 == 0);
        end
        enable = 1'b1;
        tick();

        // abort at bit 3 edge 2, then an immediate new frame
        set_cfg(8, 8, 1'b0, 1'b0);
        p = cyc;
        start = 1'b1;
        push_frame(p + 1, 1, 8, 10, 26);
        push_state(p + 26, 1'b1, 3, 2);
        push_state(p + 27, 1'b0, 0, 0);
        tick();
        start = 1'b0;
        wait_until(p + 26);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        q = cyc;
        start = 1'b1;
        push_frame(q + 1, 1, 8, 10, 80);
        push_state(q + 1, 1'b1, 0, 1);
        push_state(q + 81, 1'b0, 0, 0);
        tick();
        start = 1'b0;
        wait_until(q + 83);

        // illegal configurations: prescale 3, data_bits 9, data_bits 4
        set_cfg(3, 8, 1'b0, 1'b0);
        p = cyc;
        start = 1'b1;
        push_cfg_err(p + 1);
        push_state(p + 1, 1'b0, 0, 0);
        tick();
        start = 1'b0;
        tick();
        set_cfg(8, 9, 1'b0, 1'b0);
        p = cyc;
        start = 1'b1;
        push_cfg_err(p + 1);
        push_state(p + 1, 1'b0, 0, 0);
        tick();
        start = 1'b0;
        tick();
        set_cfg(8, 4, 1'b0, 1'b0);
        p = cyc;
        start = 1'b1;
        push_cfg_err(p + 1);
        push_state(p + 1, 1'b0, 0, 0);
        tick();
        start = 1'b0;
        tick();

        // abort in IDLE masks start: no cfg_err, no frame
        p = cyc;
        start = 1'b1;
        abort = 1'b1;
        push_state(p + 1, 1'b0, 0, 0);
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();

        // 5N1 at prescale 8; config inputs change mid-frame without effect
        set_cfg(8, 5, 1'b0, 1'b0);
        p = cyc;
        start = 1'b1;
        push_frame(p + 1, 1, 8, 7, 56);
        push_state(p + 56, 1'b1, 6, 8);
        push_state(p + 57, 1'b0, 0, 0);
        tick();
        start = 1'b0;
        wait_until(p + 10);
        set_cfg(16, 8, 1'b1, 1'b1);
        wait_until(p + 60);

        // rst mid-frame at bit 1 edge 2
        set_cfg(8, 8, 1'b0, 1'b0);
        p = cyc;
        start = 1'b1;
        push_frame(p + 1, 1, 8, 10, 10);
        push_state(p + 10, 1'b1, 1, 2);
        push_state(p + 11, 1'b0, 0, 0);
        tick();
        start = 1'b0;
        wait_until(p + 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // rst coincident with start: start not accepted
        q = cyc;
        rst   = 1'b1;
        start = 1'b1;
        push_state(q + 1, 1'b0, 0, 0);
        push_state(q + 15, 1'b0, 0, 0);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        wait_until(q + 20);

        finish_req = 1'b1;
        repeat (5) tick();
    end

endmodule
`default_nettype wire
